// File: rtl/ifmap_frame_loader.sv
// Loads one ifmap frame from a host pixel stream into the ifmap DRAM, starts
// inference, and hands the class result back to the host with a latency count.
module ifmap_frame_loader #(
    parameter int unsigned IACT_DATA_END = 784,
    parameter int unsigned CYCLE_CNT_W   = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             pix_in,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic                   DRAM_write_en,
    output logic [9:0]             DRAM_write_addr,
    output logic [7:0]             DRAM_write_data,
    output logic                   system_enable,
    input  logic [3:0]             final_out,
    input  logic                   final_out_valid,
    output logic [3:0]             result,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   busy,
    output logic [CYCLE_CNT_W-1:0] cycle_count
);

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned CLS_W  = 4;

    localparam logic [ADDR_W-1:0]      LAST_ADDR = ADDR_W'(IACT_DATA_END - 1);
    localparam logic [CYCLE_CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_RUN,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]       wr_data_q, wr_data_d;
    logic                   sys_en_q, sys_en_d;
    logic [CLS_W-1:0]       result_q, result_d;
    logic                   result_valid_q, result_valid_d;
    logic                   busy_q, busy_d;
    logic [CYCLE_CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic                   pix_hs;

    // Ready is a pure state decode so the host sees it in the first LOAD cycle.
    assign pix_ready = (state_q == S_LOAD);
    assign pix_hs    = pix_valid & pix_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pix_cnt_q      <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            sys_en_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            cycle_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            pix_cnt_q      <= pix_cnt_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            sys_en_q       <= sys_en_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            cycle_cnt_q    <= cycle_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pix_cnt_d      = pix_cnt_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        sys_en_d       = sys_en_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        cycle_cnt_d    = cycle_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_LOAD;
                    pix_cnt_d      = '0;
                    cycle_cnt_d    = '0;
                    result_d       = '0;
                    result_valid_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (pix_hs) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_cnt_q;
                    wr_data_d = pix_in;
                    pix_cnt_d = pix_cnt_q + ADDR_W'(1);
                    if (pix_cnt_q == LAST_ADDR) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            // Final write drains here so inference never reads ahead of it.
            S_FLUSH: begin
                state_d  = S_RUN;
                sys_en_d = 1'b1;
            end
            S_RUN: begin
                if (cycle_cnt_q != CNT_MAX) begin
                    cycle_cnt_d = cycle_cnt_q + CYCLE_CNT_W'(1);
                end
                if (final_out_valid) begin
                    result_d       = final_out;
                    result_valid_d = 1'b1;
                    sys_en_d       = 1'b0;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign DRAM_write_en   = wr_en_q;
    assign DRAM_write_addr = wr_addr_q;
    assign DRAM_write_data = wr_data_q;
    assign system_enable   = sys_en_q;
    assign result          = result_q;
    assign result_valid    = result_valid_q;
    assign busy            = busy_q;
    assign cycle_count     = cycle_cnt_q;

endmodule

// File: tb/tb_ifmap_frame_loader.sv
// Randomized bench for ifmap_frame_loader: a full-width instance plus a 4-bit
// latency-counter instance share the same stimulus.
`timescale 1ns/1ps
module tb_ifmap_frame_loader;

    localparam int N_PIX = 784;

    logic        clock = 1'b0;
    logic        reset, start, pix_valid, final_out_valid, result_ready;
    logic [7:0]  pix_in;
    logic [3:0]  final_out;

    logic        pix_ready, DRAM_write_en, system_enable, result_valid, busy;
    logic [9:0]  DRAM_write_addr;
    logic [7:0]  DRAM_write_data;
    logic [3:0]  result;
    logic [23:0] cycle_count;

    logic        s_pix_ready, s_DRAM_write_en, s_system_enable, s_result_valid, s_busy;
    logic [9:0]  s_DRAM_write_addr;
    logic [7:0]  s_DRAM_write_data;
    logic [3:0]  s_result;
    logic [3:0]  s_cycle_count;

    ifmap_frame_loader #(.IACT_DATA_END(784), .CYCLE_CNT_W(24)) dut (
        .clock(clock), .reset(reset), .start(start), .pix_in(pix_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .DRAM_write_en(DRAM_write_en),
        .DRAM_write_addr(DRAM_write_addr), .DRAM_write_data(DRAM_write_data),
        .system_enable(system_enable), .final_out(final_out),
        .final_out_valid(final_out_valid), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .cycle_count(cycle_count)
    );

    ifmap_frame_loader #(.IACT_DATA_END(784), .CYCLE_CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .start(start), .pix_in(pix_in),
        .pix_valid(pix_valid), .pix_ready(s_pix_ready), .DRAM_write_en(s_DRAM_write_en),
        .DRAM_write_addr(s_DRAM_write_addr), .DRAM_write_data(s_DRAM_write_data),
        .system_enable(s_system_enable), .final_out(final_out),
        .final_out_valid(final_out_valid), .result(s_result), .result_valid(s_result_valid),
        .result_ready(result_ready), .busy(s_busy), .cycle_count(s_cycle_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t  wq[$];
    wr_t  mon_w;
    int   se_rise = -1;
    logic se_prev = 1'b0;

    // Observed DRAM writes and enable rise, sampled mid-cycle.
    always @(negedge clock) begin
        if (DRAM_write_en === 1'b1) begin
            mon_w.addr = int'(DRAM_write_addr);
            mon_w.data = int'(DRAM_write_data);
            mon_w.cyc  = cyc;
            wq.push_back(mon_w);
        end
        if (system_enable === 1'b1 && se_prev !== 1'b1) se_rise = cyc;
        se_prev = system_enable;
    end

    int n_cmp = 0;
    int n_err = 0;
    int exp_pix[N_PIX];
    int hs_cyc[N_PIX];
    int last_hs;
    int ld_ready_bad;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: valid every cycle, 1: alternating, 2: random. flags bit0 pulses
    // start mid-load, bit1 pulses final_out_valid mid-load.
    task automatic load_pixels(input int mode, input int npix, input int flags);
        int  i = 0;
        int  k = 0;
        bit  v;
        ld_ready_bad = 0;
        while (i < npix) begin
            if (pix_ready !== 1'b1) ld_ready_bad++;
            case (mode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            start           = ((flags & 1) != 0) && (i == 300);
            final_out_valid = ((flags & 2) != 0) && (i == 200);
            final_out       = 4'd5;
            pix_valid       = v;
            pix_in          = 8'($urandom);
            if (v) begin
                exp_pix[i] = int'(pix_in);
                hs_cyc[i]  = cyc;
                last_hs    = cyc;
                i++;
            end
            tick();
            k++;
        end
        pix_valid       = 1'b0;
        start           = 1'b0;
        final_out_valid = 1'b0;
    endtask

    // Entered in the FLUSH cycle; leaves in the first DONE cycle.
    task automatic run_phase(input int n, input int fo, input bit pulse_start);
        tick();
        for (int k = 1; k <= n; k++) begin
            start = pulse_start && (k == n / 2);
            if (k == n) begin
                final_out_valid = 1'b1;
                final_out       = 4'(fo);
            end
            tick();
        end
        final_out_valid = 1'b0;
        start           = 1'b0;
    endtask

    task automatic host_accept();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    // Count deviations of the observed write stream from the pixel model.
    function automatic int stream_errs(input int n);
        int e = 0;
        if (wq.size() != n) e++;
        for (int i = 0; i < n && i < wq.size(); i++) begin
            if (wq[i].addr != i || wq[i].data != exp_pix[i] || wq[i].cyc != hs_cyc[i] + 1) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        logic [50:0] outs;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        outs = {pix_ready, DRAM_write_en, DRAM_write_addr, DRAM_write_data, system_enable,
                result, result_valid, busy, cycle_count};
        n_cmp++; if (outs !== 51'd0) begin n_err++; $display("FAIL reset_outputs got %h exp 0", outs); end
        n_cmp++; if (s_cycle_count !== 4'd0) begin n_err++; $display("FAIL reset_sat_count got %0d exp 0", s_cycle_count); end
        tick();
    endtask

    task automatic test_basic();
        int e;
        wq.delete();
        se_rise = -1;
        do_start();
        n_cmp++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_after_start got %b exp 1", pix_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b exp 1", busy); end
        for (int i = 0; i < N_PIX; i++) begin
            pix_valid  = 1'b1;
            pix_in     = 8'(i);
            exp_pix[i] = i % 256;
            hs_cyc[i]  = cyc;
            last_hs    = cyc;
            tick();
        end
        pix_valid = 1'b0;
        n_cmp++; if (last_hs - hs_cyc[0] !== N_PIX - 1) begin n_err++; $display("FAIL basic_consecutive got %0d exp %0d", last_hs - hs_cyc[0], N_PIX - 1); end
        n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL basic_flush_ready got %b exp 0", pix_ready); end
        n_cmp++; if (DRAM_write_en !== 1'b1 || DRAM_write_addr !== 10'd783) begin n_err++; $display("FAIL basic_flush_write got en=%b addr=%0d exp en=1 addr=783", DRAM_write_en, DRAM_write_addr); end
        n_cmp++; if (system_enable !== 1'b0) begin n_err++; $display("FAIL basic_flush_sysen got %b exp 0", system_enable); end
        run_phase(50, 7, 1'b0);
        e = stream_errs(N_PIX);
        n_cmp++; if (e !== 0) begin n_err++; $display("FAIL basic_stream got %0d bad of %0d writes exp 0 bad", e, wq.size()); end
        n_cmp++; if (se_rise !== last_hs + 2) begin n_err++; $display("FAIL basic_sysen_rise got cycle %0d exp %0d", se_rise, last_hs + 2); end
        n_cmp++; if (result !== 4'd7 || result_valid !== 1'b1) begin n_err++; $display("FAIL basic_result got %0d/%b exp 7/1", result, result_valid); end
        n_cmp++; if (system_enable !== 1'b0) begin n_err++; $display("FAIL basic_sysen_fall got %b exp 0", system_enable); end
        n_cmp++; if (cycle_count !== 24'd50) begin n_err++; $display("FAIL basic_cycle_count got %0d exp 50", cycle_count); end
        n_cmp++; if (s_cycle_count !== 4'd15) begin n_err++; $display("FAIL basic_sat_count got %0d exp 15", s_cycle_count); end
        host_accept();
        n_cmp++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_release got rv=%b busy=%b exp 0/0", result_valid, busy); end
    endtask

    task automatic test_frame(input string name, input int mode, input int flags, input int n, input int fo);
        int e;
        wq.delete();
        se_rise = -1;
        do_start();
        load_pixels(mode, N_PIX, flags);
        n_cmp++; if (ld_ready_bad !== 0) begin n_err++; $display("FAIL %s_ready_in_load got %0d low cycles exp 0", name, ld_ready_bad); end
        n_cmp++; if (pix_ready !== 1'b0 || system_enable !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL %s_flush got rdy=%b se=%b busy=%b exp 0/0/1", name, pix_ready, system_enable, busy); end
        n_cmp++; if (result !== 4'd0 || result_valid !== 1'b0) begin n_err++; $display("FAIL %s_result_in_load got %0d/%b exp 0/0", name, result, result_valid); end
        run_phase(n, fo, (flags & 1) != 0);
        e = stream_errs(N_PIX);
        n_cmp++; if (e !== 0) begin n_err++; $display("FAIL %s_stream got %0d bad of %0d writes exp 0 bad", name, e, wq.size()); end
        n_cmp++; if (se_rise !== last_hs + 2) begin n_err++; $display("FAIL %s_sysen_rise got cycle %0d exp %0d", name, se_rise, last_hs + 2); end
        n_cmp++; if (result !== 4'(fo) || result_valid !== 1'b1) begin n_err++; $display("FAIL %s_result got %0d/%b exp %0d/1", name, result, result_valid, fo); end
        n_cmp++; if (cycle_count !== 24'(n)) begin n_err++; $display("FAIL %s_cycle_count got %0d exp %0d", name, cycle_count, n); end
        n_cmp++; if (s_cycle_count !== 4'((n > 15) ? 15 : n)) begin n_err++; $display("FAIL %s_sat_count got %0d exp %0d", name, s_cycle_count, (n > 15) ? 15 : n); end
    endtask

    task automatic test_gapped();
        test_frame("gapped", 1, 0, int'($urandom_range(5, 40)), int'($urandom_range(0, 15)));
        host_accept();
    endtask

    task automatic test_ignored_events();
        test_frame("ignored", 0, 3, 30, int'($urandom_range(0, 15)));
        host_accept();
    endtask

    task automatic test_backpressure();
        int fo = int'($urandom_range(0, 15));
        int n  = int'($urandom_range(3, 25));
        test_frame("bp", 2, 0, n, fo);
        for (int k = 0; k < 10; k++) begin
            n_cmp++; if (result !== 4'(fo) || result_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_%0d got %0d/%b exp %0d/1", k, result, result_valid, fo); end
            tick();
        end
        host_accept();
        n_cmp++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_release got rv=%b busy=%b exp 0/0", result_valid, busy); end
        n_cmp++; if (cycle_count !== 24'(n) || result !== 4'(fo)) begin n_err++; $display("FAIL bp_idle_hold got cnt=%0d res=%0d exp %0d/%0d", cycle_count, result, n, fo); end
        do_start();
        n_cmp++; if (pix_ready !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL bp_restart got rdy=%b busy=%b exp 1/1", pix_ready, busy); end
        n_cmp++; if (cycle_count !== 24'd0 || result !== 4'd0) begin n_err++; $display("FAIL bp_restart_clear got cnt=%0d res=%0d exp 0/0", cycle_count, result); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        logic [50:0] outs;
        do_start();
        load_pixels(2, 300, 0);
        pix_valid = 1'b1;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        outs = {pix_ready, DRAM_write_en, DRAM_write_addr, DRAM_write_data, system_enable,
                result, result_valid, busy, cycle_count};
        n_cmp++; if (outs !== 51'd0) begin n_err++; $display("FAIL rstload_outputs got %h exp 0", outs); end
        wq.delete();
        for (int k = 0; k < 5; k++) tick();
        pix_valid = 1'b0;
        n_cmp++; if (wq.size() !== 0) begin n_err++; $display("FAIL rstload_no_strobe got %0d writes exp 0", wq.size()); end
        test_frame("rstload_fresh", 0, 0, 10, int'($urandom_range(0, 15)));
        host_accept();
    endtask

    task automatic test_reset_in_run();
        do_start();
        load_pixels(0, N_PIX, 0);
        for (int k = 0; k < 8; k++) tick();
        n_cmp++; if (system_enable !== 1'b1 || cycle_count !== 24'd7) begin n_err++; $display("FAIL rstrun_pre got se=%b cnt=%0d exp 1/7", system_enable, cycle_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (system_enable !== 1'b0 || busy !== 1'b0 || cycle_count !== 24'd0) begin n_err++; $display("FAIL rstrun_post got se=%b busy=%b cnt=%0d exp 0/0/0", system_enable, busy, cycle_count); end
        n_cmp++; if (s_cycle_count !== 4'd0 || s_system_enable !== 1'b0) begin n_err++; $display("FAIL rstrun_sat got cnt=%0d se=%b exp 0/0", s_cycle_count, s_system_enable); end
        tick();
    endtask

    task automatic test_saturation();
        test_frame("sat", 2, 0, 20, 9);
        host_accept();
        for (int k = 0; k < 5; k++) tick();
        n_cmp++; if (s_cycle_count !== 4'd15 || s_result !== 4'd9) begin n_err++; $display("FAIL sat_idle_hold got cnt=%0d res=%0d exp 15/9", s_cycle_count, s_result); end
        do_start();
        n_cmp++; if (s_cycle_count !== 4'd0 || s_result !== 4'd0 || s_result_valid !== 1'b0) begin n_err++; $display("FAIL sat_start_clear got cnt=%0d res=%0d rv=%b exp 0/0/0", s_cycle_count, s_result, s_result_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_random_frames();
        test_frame("rand_min_run", 2, 0, 1, int'($urandom_range(0, 15)));
        host_accept();
        for (int f = 0; f < 2; f++) begin
            test_frame("rand", 2, 0, int'($urandom_range(1, 60)), int'($urandom_range(0, 15)));
            host_accept();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
        final_out = '0; final_out_valid = 1'b0; result_ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_gapped();
        test_ignored_events();
        test_backpressure();
        test_reset_mid_load();
        test_reset_in_run();
        test_saturation();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifmap_frame_loader.md
# ifmap_frame_loader

Front-end sequencer placed directly upstream of the accelerator top interface. It accepts one 28x28 8-bit ifmap frame from the host over a valid/ready stream and writes it into the ifmap DRAM at addresses 0..783. It then drives `system_enable` to start inference and captures the 4-bit class result, returning it to the host over a valid/ready handshake. A saturating counter records inference latency in cycles.

## Interface
Parameters:
- `IACT_DATA_END`, 784: number of ifmap bytes per frame; the last DRAM address is `IACT_DATA_END-1`.
- `CYCLE_CNT_W`, 24: width of the inference latency counter.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state and outputs.
- `start`  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- `pix_in`  in  8  pixel byte.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_ready`  out  1  loader accepts a pixel this cycle.
- `DRAM_write_en`  out  1  registered write strobe to the ifmap DRAM.
- `DRAM_write_addr`  out  10  write address, 0..783.
- `DRAM_write_data`  out  8  write data.
- `system_enable`  out  1  inference enable to the accelerator top; held high for the whole RUN state.
- `final_out`  in  4  class index from the accelerator.
- `final_out_valid`  in  1  `final_out` is valid; sampled only in RUN.
- `result`  out  4  latched class index.
- `result_valid`  out  1  `result` is available to the host.
- `result_ready`  in  1  host accepts `result`.
- `busy`  out  1  high in every state except IDLE.
- `cycle_count`  out  CYCLE_CNT_W  number of inference cycles for the last or current frame.

## Operation
- States: IDLE, LOAD, FLUSH, RUN, DONE.
- IDLE: `start`=1 moves to LOAD. On the same edge, the pixel counter and `cycle_count` clear to 0. `result`/`result_valid` clear to 0 when the next frame starts.
- LOAD: `pix_ready`=1, driven combinationally from the state. A handshake is `pix_valid & pix_ready`. On a handshake, the next cycle carries `DRAM_write_en`=1, `DRAM_write_addr`=counter, and `DRAM_write_data`=`pix_in`; the counter then increments. Cycles with no handshake produce `DRAM_write_en`=0, and address/data hold their last values. A handshake with counter=`IACT_DATA_END-1` moves to FLUSH.
- FLUSH: lasts exactly one cycle. The last DRAM write strobe is active in this cycle and `pix_ready`=0. The state then moves to RUN.
- RUN: `system_enable`=1 is registered and high from the first RUN cycle. `cycle_count` increments every RUN cycle, including the cycle in which `final_out_valid` is seen, and saturates at all-ones. When `final_out_valid`=1, `result`<=`final_out` and `result_valid`<=1, `system_enable` goes low on the same edge, and the state moves to DONE.
- DONE: `result_valid`=1 and `result` is held. When `result_ready`=1, `result_valid` goes low on the next edge and the state returns to IDLE. `cycle_count` holds its value until the next `start`.
- `start` is ignored in LOAD, FLUSH, RUN and DONE.
- `final_out_valid` is ignored outside RUN.
- `pix_valid` is ignored outside LOAD; pixels presented then are not consumed.
- Counter width: 10 bits, values 0..783, never wraps within a frame.
- Reset takes effect in any state, including mid-LOAD or mid-RUN. On the next edge the state is IDLE and all outputs are 0: `pix_ready`, `DRAM_write_en`, `DRAM_write_addr`, `DRAM_write_data`, `system_enable`, `result`, `result_valid`, `busy`, `cycle_count`. Any partial frame is abandoned, and no write strobe occurs after reset.

## Timing
- `start` at edge t gives `pix_ready`=1 from cycle t+1.
- Handshake latency: a handshake in cycle c produces the DRAM write strobe in cycle c+1.
- With `pix_valid` held high, 784 pixels are accepted in 784 consecutive cycles.
- If the last handshake is in cycle c:
  - the last write is in cycle c+1 (FLUSH);
  - `system_enable` rises in cycle c+2.
  - This guarantees that no DRAM read is enabled before all writes have completed.
- `final_out_valid` in cycle r gives:
  - `system_enable`=0 and `result_valid`=1 in cycle r+1;
  - `cycle_count` = number of RUN cycles, counted inclusively from RUN entry through cycle r.
- Minimum IDLE-to-IDLE time: 1 + 784 + 1 + RUN + 1 cycles.

## Test plan
- **Basic frame:** `start`, then 784 pixels `pix_in`=addr[7:0] with `pix_valid` held high. Required:
  - 784 write strobes, addresses 0..783, data = addr[7:0];
  - `system_enable` rises 2 cycles after the last handshake;
  - `final_out`=7 with valid after 50 RUN cycles gives `result`=7, `result_valid`=1, `cycle_count`=50.
- **Gapped input:** `pix_valid` toggled 1/0 every cycle. Required: still exactly 784 strobes, no strobe in gap cycles, addresses contiguous, FLUSH lasts one cycle.
- **Ignored events:**
  - `start` pulsed mid-LOAD and mid-RUN: no state change and no counter clear.
  - `final_out_valid` asserted in LOAD: `result` unchanged, still 0.
- **Host backpressure:** `result_ready` held low for 10 cycles in DONE. Required:
  - `result_valid` and `result` stable for those cycles;
  - the cycle after `result_ready`=1, `result_valid`=0, `busy`=0;
  - a new `start` is then accepted.
- **Reset mid-operation:** `reset` after 300 pixels. Required:
  - all outputs 0 the next cycle, no further strobes;
  - a fresh frame writes starting at address 0.
  - Repeat the reset in RUN: `system_enable`=0 on the next cycle.
- **Saturation:** `CYCLE_CNT_W`=4 with `final_out_valid` after 20 RUN cycles. Required: `cycle_count`=15, held until the next `start`, which clears it to 0.
